// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill read path: FSM states,
// requester IDs and the default line/burst geometry.
package cache_pkg;

  localparam int unsigned CACHE_LINE_BYTES = 32;
  localparam int unsigned CACHE_BEAT_BYTES = 4;
  localparam int unsigned CACHE_BURST_LEN  = CACHE_LINE_BYTES / CACHE_BEAT_BYTES;

  // Requester IDs double as bit indices into {dc, ic} request vectors
  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    RSP  = 3'b100
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one that was
// not served last wins.
module rr_arb2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any_c,
  output logic       grant_c
);

  assign any_c = |req;

  always_comb begin
    grant_c = IC;
    if (&req)        grant_c = ~last_grant;
    else if (req[DC]) grant_c = DC;
  end

endmodule

// File: rtl/cache_mem_rd_arbiter.sv
// Shares one memory read channel between I-cache and D-cache refills; the grant
// is held from request handshake through the last beat, with burst-length check.
module cache_mem_rd_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = CACHE_BURST_LEN,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  from_ic_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_ic_rd_req_addr,
  output logic                  to_ic_rd_req_ready,
  output logic                  to_ic_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_ic_rd_rsp_data,
  output logic                  to_ic_rd_rsp_last,
  input  logic                  from_ic_rd_rsp_ready,
  input  logic                  from_dc_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_dc_rd_req_addr,
  output logic                  to_dc_rd_req_ready,
  output logic                  to_dc_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_dc_rd_rsp_data,
  output logic                  to_dc_rd_rsp_last,
  input  logic                  from_dc_rd_rsp_ready,
  output logic                  to_mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
  input  logic                  from_mem_rd_req_ready,
  input  logic                  from_mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
  input  logic                  from_mem_rd_rsp_last,
  output logic                  to_mem_rd_rsp_ready,
  output logic                  burst_err
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  arb_state_e            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  burst_err_d;
  logic                  arb_any_c, arb_grant_c;
  logic                  granted_rsp_ready;
  logic                  beat_hs;

  rr_arb2 u_rr_arb2 (
    .req        ({from_dc_rd_req_valid, from_ic_rd_req_valid}),
    .last_grant (last_grant_q),
    .any_c      (arb_any_c),
    .grant_c    (arb_grant_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= IC;
      last_grant_q <= DC;
      beat_cnt_q   <= '0;
      addr_q       <= '0;
      burst_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      addr_q       <= addr_d;
      burst_err    <= burst_err_d;
    end
  end

  // Next state plus request/response routing toward the granted cache only
  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    last_grant_d        = last_grant_q;
    beat_cnt_d          = beat_cnt_q;
    addr_d              = addr_q;
    burst_err_d         = burst_err;
    beat_hs             = 1'b0;
    to_ic_rd_req_ready  = 1'b0;
    to_dc_rd_req_ready  = 1'b0;
    to_ic_rd_rsp_valid  = 1'b0;
    to_ic_rd_rsp_data   = '0;
    to_ic_rd_rsp_last   = 1'b0;
    to_dc_rd_rsp_valid  = 1'b0;
    to_dc_rd_rsp_data   = '0;
    to_dc_rd_rsp_last   = 1'b0;
    to_mem_rd_req_valid = 1'b0;
    to_mem_rd_req_addr  = '0;
    to_mem_rd_rsp_ready = 1'b0;
    granted_rsp_ready   = (grant_q == DC) ? from_dc_rd_rsp_ready : from_ic_rd_rsp_ready;

    case (state_q)
      IDLE: begin
        if (arb_any_c) begin
          grant_d = arb_grant_c;
          addr_d  = (arb_grant_c == DC) ? from_dc_rd_req_addr : from_ic_rd_req_addr;
          state_d = REQ;
        end
      end
      REQ: begin
        to_mem_rd_req_valid = 1'b1;
        to_mem_rd_req_addr  = addr_q;
        if (grant_q == DC) to_dc_rd_req_ready = from_mem_rd_req_ready;
        else               to_ic_rd_req_ready = from_mem_rd_req_ready;
        if (from_mem_rd_req_ready) begin
          beat_cnt_d = '0;
          state_d    = RSP;
        end
      end
      RSP: begin
        to_mem_rd_rsp_ready = granted_rsp_ready;
        if (grant_q == DC) begin
          to_dc_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_dc_rd_rsp_data  = from_mem_rd_rsp_data;
          to_dc_rd_rsp_last  = from_mem_rd_rsp_last;
        end else begin
          to_ic_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_ic_rd_rsp_data  = from_mem_rd_rsp_data;
          to_ic_rd_rsp_last  = from_mem_rd_rsp_last;
        end
        beat_hs = from_mem_rd_rsp_valid && granted_rsp_ready;
        if (beat_hs) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          // Last must coincide exactly with the final expected beat
          if (from_mem_rd_rsp_last != (beat_cnt_q == LAST_BEAT)) burst_err_d = 1'b1;
          if (from_mem_rd_rsp_last) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_rd_arbiter.sv
// Bench for cache_mem_rd_arbiter: a cycle table, directed corner sequences and a
// randomized run checked against a transaction-level channel-owner model.
module tb_cache_mem_rd_arbiter;

  localparam int BL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        from_ic_rd_req_valid = 1'b0, from_dc_rd_req_valid = 1'b0;
  logic [31:0] from_ic_rd_req_addr = '0, from_dc_rd_req_addr = '0;
  logic        from_ic_rd_rsp_ready = 1'b0, from_dc_rd_rsp_ready = 1'b0;
  logic        from_mem_rd_req_ready = 1'b0, from_mem_rd_rsp_valid = 1'b0;
  logic [31:0] from_mem_rd_rsp_data = '0;
  logic        from_mem_rd_rsp_last = 1'b0;
  logic        to_ic_rd_req_ready, to_ic_rd_rsp_valid, to_ic_rd_rsp_last;
  logic        to_dc_rd_req_ready, to_dc_rd_rsp_valid, to_dc_rd_rsp_last;
  logic [31:0] to_ic_rd_rsp_data, to_dc_rd_rsp_data, to_mem_rd_req_addr;
  logic        to_mem_rd_req_valid, to_mem_rd_rsp_ready, burst_err;

  always #5 clk = ~clk;

  cache_mem_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .from_ic_rd_req_valid(from_ic_rd_req_valid), .from_ic_rd_req_addr(from_ic_rd_req_addr),
    .to_ic_rd_req_ready(to_ic_rd_req_ready), .to_ic_rd_rsp_valid(to_ic_rd_rsp_valid),
    .to_ic_rd_rsp_data(to_ic_rd_rsp_data), .to_ic_rd_rsp_last(to_ic_rd_rsp_last),
    .from_ic_rd_rsp_ready(from_ic_rd_rsp_ready),
    .from_dc_rd_req_valid(from_dc_rd_req_valid), .from_dc_rd_req_addr(from_dc_rd_req_addr),
    .to_dc_rd_req_ready(to_dc_rd_req_ready), .to_dc_rd_rsp_valid(to_dc_rd_rsp_valid),
    .to_dc_rd_rsp_data(to_dc_rd_rsp_data), .to_dc_rd_rsp_last(to_dc_rd_rsp_last),
    .from_dc_rd_rsp_ready(from_dc_rd_rsp_ready),
    .to_mem_rd_req_valid(to_mem_rd_req_valid), .to_mem_rd_req_addr(to_mem_rd_req_addr),
    .from_mem_rd_req_ready(from_mem_rd_req_ready), .from_mem_rd_rsp_valid(from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data(from_mem_rd_rsp_data), .from_mem_rd_rsp_last(from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready(to_mem_rd_rsp_ready), .burst_err(burst_err)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // in = {rst_n, ic_v, dc_v, mem_req_rdy, mem_rsp_v, mem_rsp_last, ic_rsp_rdy, dc_rsp_rdy}
  // e  = {ic_req_rdy, dc_req_rdy, ic_rsp_v, dc_rsp_v, mem_rsp_rdy, burst_err}
  typedef struct {
    logic [7:0]  in;
    logic        chk;
    logic        e_mrqv;
    logic [31:0] e_addr;
    logic [5:0]  e;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] in, input logic c, input logic mv,
                     input logic [31:0] a, input logic [5:0] e);
    vec_t v;
    v.in = in; v.chk = c; v.e_mrqv = mv; v.e_addr = a; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic run_table();
    vec_t v;
    logic [31:0] md;
    string p;
    from_ic_rd_req_addr = 32'h0000_1020;
    from_dc_rd_req_addr = 32'h0000_2040;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      md = 32'hD000_0000 + 32'(i);
      @(posedge clk); #1;
      {rst_n, from_ic_rd_req_valid, from_dc_rd_req_valid, from_mem_rd_req_ready,
       from_mem_rd_rsp_valid, from_mem_rd_rsp_last, from_ic_rd_rsp_ready,
       from_dc_rd_rsp_ready} = v.in;
      from_mem_rd_rsp_data = md;
      #4;
      if (v.chk) begin
        p = $sformatf("row%0d ", i);
        chk({p, "mem_req_valid"}, 32'(to_mem_rd_req_valid), 32'(v.e_mrqv));
        if (v.e_mrqv) chk({p, "mem_req_addr"}, to_mem_rd_req_addr, v.e_addr);
        chk({p, "req_ready"}, 32'({to_ic_rd_req_ready, to_dc_rd_req_ready}), 32'(v.e[5:4]));
        chk({p, "rsp_valid"}, 32'({to_ic_rd_rsp_valid, to_dc_rd_rsp_valid}), 32'(v.e[3:2]));
        chk({p, "mem_rsp_ready"}, 32'(to_mem_rd_rsp_ready), 32'(v.e[1]));
        chk({p, "burst_err"}, 32'(burst_err), 32'(v.e[0]));
        if (v.e[3]) begin
          chk({p, "ic_data"}, to_ic_rd_rsp_data, md);
          chk({p, "ic_last"}, 32'(to_ic_rd_rsp_last), 32'(v.in[2]));
          chk({p, "dc_data_zero"}, to_dc_rd_rsp_data, 32'h0);
        end
        if (v.e[2]) begin
          chk({p, "dc_data"}, to_dc_rd_rsp_data, md);
          chk({p, "dc_last"}, 32'(to_dc_rd_rsp_last), 32'(v.in[2]));
          chk({p, "ic_data_zero"}, to_ic_rd_rsp_data, 32'h0);
        end
      end
    end
  endtask

  // Bench-side caches/memory and the channel-owner model (0 = IC, 1 = DC)
  bit          req_v[2], outst[2], rsp_rdy[2];
  logic [31:0] req_addr[2];
  int          rcv_idx[2];
  bit          mem_busy;
  int          mem_len, mem_idx;
  bit          m_free = 1'b1, m_acc, m_err;
  int          m_owner, m_last = 1;
  logic [31:0] m_addr;
  int          served_q[$];
  int          k_req[2], k_mrq, k_rsv, k_rsr, k_bad, k_rrst, k_len;
  bit          k_rst;

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic model_reset();
    m_free = 1'b1; m_acc = 1'b0; m_err = 1'b0; m_last = 1; mem_busy = 1'b0;
    for (int r = 0; r < 2; r++) begin
      req_v[r] = 1'b0; outst[r] = 1'b0; rcv_idx[r] = 0;
    end
  endtask

  task automatic check_cycle();
    logic oq, xq, ov, xv, ol, xl;
    logic [31:0] od, xd;
    bit exp_last;
    chk("burst_err", 32'(burst_err), 32'(m_err));
    if (m_owner == 1) begin
      oq = to_dc_rd_req_ready; ov = to_dc_rd_rsp_valid; od = to_dc_rd_rsp_data; ol = to_dc_rd_rsp_last;
      xq = to_ic_rd_req_ready; xv = to_ic_rd_rsp_valid; xd = to_ic_rd_rsp_data; xl = to_ic_rd_rsp_last;
    end else begin
      oq = to_ic_rd_req_ready; ov = to_ic_rd_rsp_valid; od = to_ic_rd_rsp_data; ol = to_ic_rd_rsp_last;
      xq = to_dc_rd_req_ready; xv = to_dc_rd_rsp_valid; xd = to_dc_rd_rsp_data; xl = to_dc_rd_rsp_last;
    end
    if (m_free) begin
      chk("idle_outputs", 32'({to_mem_rd_req_valid, to_ic_rd_req_ready, to_dc_rd_req_ready,
                               to_ic_rd_rsp_valid, to_dc_rd_rsp_valid, to_mem_rd_rsp_ready}), 32'h0);
    end else if (!m_acc) begin
      chk("req_valid", 32'(to_mem_rd_req_valid), 32'h1);
      chk("req_addr", to_mem_rd_req_addr, m_addr);
      chk("owner_req_ready", 32'(oq), 32'(from_mem_rd_req_ready));
      chk("other_req_ready", 32'(xq), 32'h0);
      chk("req_rsp_quiet", 32'({to_ic_rd_rsp_valid, to_dc_rd_rsp_valid, to_mem_rd_rsp_ready}), 32'h0);
    end else begin
      exp_last = (rcv_idx[m_owner] == mem_len - 1);
      chk("rsp_req_quiet", 32'({to_mem_rd_req_valid, to_ic_rd_req_ready, to_dc_rd_req_ready}), 32'h0);
      chk("owner_rsp_valid", 32'(ov), 32'(from_mem_rd_rsp_valid));
      if (from_mem_rd_rsp_valid) begin
        chk("owner_rsp_data", od, m_addr + 32'(rcv_idx[m_owner]));
        chk("owner_rsp_last", 32'(ol), 32'(exp_last));
      end
      chk("other_rsp", 32'({xv, xl}) | xd, 32'h0);
      chk("mem_rsp_ready", 32'(to_mem_rd_rsp_ready), 32'(rsp_rdy[m_owner]));
    end
  endtask

  task automatic update_model();
    bit last;
    if (!rst_n) begin
      model_reset();
    end else if (m_free) begin
      if (req_v[0] || req_v[1]) begin
        m_owner = (req_v[0] && req_v[1]) ? 1 - m_last : (req_v[1] ? 1 : 0);
        m_addr  = req_addr[m_owner];
        m_free  = 1'b0;
        m_acc   = 1'b0;
      end
    end else if (!m_acc) begin
      if (from_mem_rd_req_ready) begin
        m_acc = 1'b1;
        served_q.push_back(m_owner);
        req_v[m_owner] = 1'b0; outst[m_owner] = 1'b1; rcv_idx[m_owner] = 0;
        mem_busy = 1'b1; mem_idx = 0;
        mem_len = (k_len != 0) ? k_len : (pct(k_bad) ? int'($urandom_range(12, 1)) : BL);
      end
    end else if (from_mem_rd_rsp_valid && rsp_rdy[m_owner]) begin
      last = (mem_idx == mem_len - 1);
      // The BL-th beat of a burst must be its last, and no other beat may be
      if (last != (mem_idx + 1 == BL)) m_err = 1'b1;
      rcv_idx[m_owner]++;
      mem_idx++;
      if (last) begin
        m_free = 1'b1; m_last = m_owner; outst[m_owner] = 1'b0; mem_busy = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    rst_n = !(k_rst || (int'($urandom_range(999, 0)) < k_rrst));
    for (int r = 0; r < 2; r++) begin
      if (!req_v[r] && !outst[r] && pct(k_req[r])) begin
        req_v[r] = 1'b1;
        req_addr[r] = $urandom() & 32'hFFFF_FFE0;
      end
      rsp_rdy[r] = pct(k_rsr);
    end
    from_ic_rd_req_valid  = req_v[0];
    from_ic_rd_req_addr   = req_addr[0];
    from_dc_rd_req_valid  = req_v[1];
    from_dc_rd_req_addr   = req_addr[1];
    from_ic_rd_rsp_ready  = rsp_rdy[0];
    from_dc_rd_rsp_ready  = rsp_rdy[1];
    from_mem_rd_req_ready = pct(k_mrq);
    from_mem_rd_rsp_valid = mem_busy && pct(k_rsv);
    from_mem_rd_rsp_data  = mem_busy ? m_addr + 32'(mem_idx) : $urandom();
    from_mem_rd_rsp_last  = mem_busy && (mem_idx == mem_len - 1);
    #4;
    check_cycle();
    update_model();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic knobs(input int ri, input int rd, input int mrq, input int rsv, input int rsr);
    k_req[0] = ri; k_req[1] = rd; k_mrq = mrq; k_rsv = rsv; k_rsr = rsr;
  endtask

  task automatic do_reset();
    k_rst = 1'b1; cycle(); k_rst = 1'b0;
  endtask

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    add(8'b0000_0000, 0, 0, 32'h0,    6'b000000);
    add(8'b1100_0000, 1, 0, 32'h0,    6'b000000);
    add(8'b1100_0000, 1, 1, 32'h1020, 6'b000000);
    add(8'b1101_0000, 1, 1, 32'h1020, 6'b100000);
    add(8'b1000_1010, 1, 0, 32'h0,    6'b001010);
    add(8'b1000_1000, 1, 0, 32'h0,    6'b001000);
    for (int i = 0; i < 6; i++) add(8'b1000_1010, 1, 0, 32'h0, 6'b001010);
    add(8'b1000_1110, 1, 0, 32'h0,    6'b001010);
    add(8'b1110_0000, 1, 0, 32'h0,    6'b000000);
    add(8'b1111_0000, 1, 1, 32'h2040, 6'b010000);
    add(8'b1000_1101, 1, 0, 32'h0,    6'b000110);
    add(8'b1000_0000, 1, 0, 32'h0,    6'b000001);
    add(8'b0000_0000, 1, 0, 32'h0,    6'b000001);
    add(8'b1000_0000, 1, 0, 32'h0,    6'b000000);
    run_table();

    k_bad = 0; k_rrst = 0; k_len = 0; k_rst = 1'b0;

    // Both caches always requesting: service must alternate IC, DC, IC, DC
    knobs(0, 0, 100, 100, 100);
    do_reset();
    served_q.delete();
    knobs(100, 100, 100, 100, 100);
    cycles(45);
    chk("rr_bursts_seen", 32'(served_q.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order%0d", i), (i < served_q.size()) ? 32'(served_q[i]) : 32'hFFFF_FFFF,
          32'(exp_order[i]));

    // IC alone: request stalled 5 cycles, then a 3-cycle rsp_ready gap mid-burst
    knobs(0, 0, 0, 0, 0);
    do_reset();
    served_q.delete();
    knobs(100, 0, 0, 100, 100);
    cycles(6);
    k_req[0] = 0;
    k_mrq = 100;
    cycle();
    chk("stall_then_accept_ic", (served_q.size() == 1) ? 32'(served_q[0]) : 32'hFFFF_FFFF, 32'h0);
    cycles(3);
    k_rsr = 0;
    cycles(3);
    k_rsr = 100;
    cycles(8);
    chk("ic_beats_delivered", 32'(rcv_idx[0]), 32'(BL));
    chk("dc_beats_delivered", 32'(rcv_idx[1]), 32'h0);
    chk("burst_err_clean", 32'(burst_err), 32'h0);

    // Short (6-beat) burst sets the sticky error; reset mid-burst clears it
    knobs(0, 0, 0, 0, 0);
    do_reset();
    knobs(100, 0, 100, 100, 100);
    k_len = 6;
    cycles(10);
    chk("short_burst_err", 32'(burst_err), 32'h1);
    k_len = 0;
    cycles(6);
    chk("err_sticky", 32'(burst_err), 32'h1);
    do_reset();
    cycle();
    chk("rst_clears_err", 32'(burst_err), 32'h0);

    // Randomized traffic with occasional bad lengths and resets
    knobs(0, 0, 0, 0, 0);
    do_reset();
    knobs(30, 30, 60, 70, 70);
    k_bad = 10;
    k_rrst = 4;
    cycles(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
